// File: rtl/systolic_mac.sv
// Output-stationary systolic array processing element: forwards A east and B south
// with one register stage each, and accumulates A*B into a local result register.
module systolic_mac #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] A_in,
  input  logic [DATA_WIDTH-1:0] B_in,
  output logic [DATA_WIDTH-1:0] A_out,
  output logic [DATA_WIDTH-1:0] B_out,
  output logic [DATA_WIDTH-1:0] C_out
);

  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] c_q, c_d;
  logic [DATA_WIDTH-1:0] prod_lo;

  // The accumulator keeps only the low DATA_WIDTH bits, and those bits of a full-width
  // product depend only on the low bits of the operands, so the upper half is never built.
  always_comb begin
    prod_lo = A_in * B_in;
    a_d     = A_in;
    b_d     = B_in;
    c_d     = c_q + prod_lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
    end
  end

  assign A_out = a_q;
  assign B_out = b_q;
  assign C_out = c_q;

endmodule

// File: tb/tb_systolic_mac.sv
// Directed scoreboard bench for systolic_mac at DATA_WIDTH=32 and DATA_WIDTH=8.
module tb_systolic_mac;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] a_in, b_in;
  logic [31:0] a_out, b_out, c_out;

  logic        rst8;
  logic [7:0]  a8_in, b8_in;
  logic [7:0]  a8_out, b8_out, c8_out;

  exp_t        sb_q[$];
  exp_t        sb8_q[$];
  logic [31:0] mc;
  logic [7:0]  mc8;
  int          errors;
  int          checks;

  systolic_mac #(.DATA_WIDTH(32)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .A_in (a_in),
    .B_in (b_in),
    .A_out(a_out),
    .B_out(b_out),
    .C_out(c_out)
  );

  systolic_mac #(.DATA_WIDTH(8)) u_dut8 (
    .clk  (clk),
    .rst  (rst8),
    .A_in (a8_in),
    .B_in (b8_in),
    .A_out(a8_out),
    .B_out(b8_out),
    .C_out(c8_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of the 32-bit PE: drive, push the model's prediction, pop and compare.
  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic r,
                      input string tag);
    exp_t e;
    a_in = a;
    b_in = b;
    rst  = r;
    if (r) mc = '0;
    else   mc = mc + a * b;
    e.a = r ? 32'd0 : a;
    e.b = r ? 32'd0 : b;
    e.c = mc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".A_out"}, a_out, e.a);
    chk({tag, ".B_out"}, b_out, e.b);
    chk({tag, ".C_out"}, c_out, e.c);
  endtask

  task automatic step8(input logic [7:0] a, input logic [7:0] b, input logic r,
                       input string tag);
    exp_t e;
    a8_in = a;
    b8_in = b;
    rst8  = r;
    if (r) mc8 = '0;
    else   mc8 = mc8 + a * b;
    e.a = {24'd0, r ? 8'd0 : a};
    e.b = {24'd0, r ? 8'd0 : b};
    e.c = {24'd0, mc8};
    sb8_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb8_q.pop_front();
    chk({tag, ".A_out8"}, {24'd0, a8_out}, e.a);
    chk({tag, ".B_out8"}, {24'd0, b8_out}, e.b);
    chk({tag, ".C_out8"}, {24'd0, c8_out}, e.c);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    mc     = '0;
    mc8    = '0;
    rst    = 1'b1;
    rst8   = 1'b1;
    a_in   = '0;
    b_in   = '0;
    a8_in  = '0;
    b8_in  = '0;

    // Reset held for two edges with live operands, then release.
    step(32'd5, 32'd7, 1'b1, "rst0");
    step(32'd5, 32'd7, 1'b1, "rst1");
    step(32'd5, 32'd7, 1'b0, "rel");
    chk("rel.C35", c_out, 32'd35);

    // Dot product (1,4),(2,5),(3,6) then idle zeros.
    step(32'd0, 32'd0, 1'b1, "dp.rst");
    step(32'd1, 32'd4, 1'b0, "dp0");
    step(32'd2, 32'd5, 1'b0, "dp1");
    step(32'd3, 32'd6, 1'b0, "dp2");
    step(32'd0, 32'd0, 1'b0, "dp3");
    step(32'd0, 32'd0, 1'b0, "dp4");
    chk("dp.C32", c_out, 32'd32);

    // Reset mid-accumulation discards the partial sum.
    step(32'd9, 32'd9, 1'b1, "mid.rst");
    step(32'd9, 32'd9, 1'b0, "mid");
    chk("mid.C81", c_out, 32'd81);

    // Modular wrap of the accumulator.
    step(32'd0, 32'd0, 1'b1, "ovf.rst");
    step(32'h0000FFFF, 32'h0000FFFF, 1'b0, "ovf0");
    chk("ovf0.C", c_out, 32'hFFFE0001);
    step(32'h0001FFFF, 32'h00008000, 1'b0, "ovf1");
    chk("ovf1.C", c_out, 32'hFFFD8001);

    // All-ones operands, then wrap from 0xFFFFFFFF to 0.
    step(32'd0, 32'd0, 1'b1, "max.rst");
    step(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "max");
    chk("max.C", c_out, 32'h00000001);
    chk("max.A", a_out, 32'hFFFFFFFF);
    step(32'hFFFFFFFE, 32'd1, 1'b0, "pre");
    chk("pre.C", c_out, 32'hFFFFFFFF);
    step(32'd1, 32'd1, 1'b0, "wrap");
    chk("wrap.C", c_out, 32'h00000000);

    // Narrow instance; the wide one is parked in reset meanwhile.
    rst = 1'b1;
    step8(8'd0, 8'd0, 1'b1, "w8.rst");
    step8(8'd16, 8'd16, 1'b0, "w8a");
    chk("w8a.C", {24'd0, c8_out}, 32'h00);
    step8(8'd3, 8'd3, 1'b0, "w8b");
    chk("w8b.C", {24'd0, c8_out}, 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_mac.md
Name: systolic_mac

Overview:
- Single processing element (PE) of an N x N output-stationary systolic array used for matrix multiplication.
- Each cycle it multiplies the incoming A and B operands and adds the product into a local accumulator.
- It forwards A one column to the right (A_out) and B one row down (B_out), each with a one-cycle register delay.
- The parent array tiles these PEs and exposes every PE's accumulator as one slice of a flat result bus.

Parameters:
- DATA_WIDTH, 32, width in bits of the A/B operands, the forwarded operands and the accumulator.

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- A_in  input  DATA_WIDTH  row operand, from the west neighbour or the array edge.
- B_in  input  DATA_WIDTH  column operand, from the north neighbour or the array edge.
- A_out  output  DATA_WIDTH  registered copy of A_in, driven to the east neighbour.
- B_out  output  DATA_WIDTH  registered copy of B_in, driven to the south neighbour.
- C_out  output  DATA_WIDTH  registered accumulator value (this PE's element of C).

Behaviour:
- All outputs are registers; no combinational path from any input to any output.
- Reset (rst=1 at posedge): A_out=0, B_out=0, C_out=0. Reset has priority over everything else.
  - Reset asserted mid-accumulation discards the partial sum on that edge.
  - While rst is held, all outputs stay 0 regardless of inputs.
- Normal edge (rst=0):
  - A_out <= A_in.
  - B_out <= B_in.
  - C_out <= C_out + (A_in * B_in).
- Arithmetic:
  - The product is computed at full 2*DATA_WIDTH width.
  - Only the low DATA_WIDTH bits of (C_out + product) are kept, i.e. modulo 2^DATA_WIDTH.
  - No saturation and no overflow flag.
  - Result bits are identical whether operands are treated as unsigned or two's complement. Implement as unsigned.
- Latency:
  - Operands present before edge k appear on A_out/B_out after edge k (1 cycle).
  - Their product is included in C_out after edge k (1 cycle).
- The accumulator runs every cycle; there is no enable and no clear other than rst.
  - A zero operand on either input leaves C_out unchanged but still forwards both operands.
  - The parent feeds zeros for idle/skew slots.
- No handshake. The PE is always ready; data is valid every cycle by convention.
- Wrap-around example (DATA_WIDTH=32): C_out=0xFFFFFFFF, A_in=1, B_in=1 -> C_out=0x00000000 next cycle.
- X/uninitialised state is not permitted on outputs after the first reset edge.

Test Plan:
- Reset: drive A_in=5, B_in=7, rst=1 for 2 cycles -> A_out=B_out=C_out=0 every cycle; deassert rst -> next edge A_out=5, B_out=7, C_out=35.
- Dot product: after reset, feed pairs (1,4),(2,5),(3,6) on consecutive cycles, then zeros -> C_out sequence 4, 14, 32, then holds 32. A_out sequence 1,2,3,0 and B_out sequence 4,5,6,0, each lagging its input by one cycle.
- Overflow wrap: preload by feeding (0xFFFF,0xFFFF) -> C_out=0xFFFE0001. Then feed (0x0001FFFF,0x8000) -> product low bits 0xFFFF8000, C_out=0xFFFD8001 (mod 2^32).
- Mid-run reset: accumulate to 32 as in the dot-product case, assert rst for one cycle while A_in=9, B_in=9 -> all outputs 0. Next cycle with (9,9) -> C_out=81.
- Max operands: A_in=B_in=0xFFFFFFFF from C_out=0 -> C_out=0x00000001. A_out and B_out both equal 0xFFFFFFFF.
- Parameter sweep: DATA_WIDTH=8, feed (16,16) from 0 -> C_out=0x00. Then (3,3) -> C_out=9.
